// File: rtl/hub_pkg.sv
// Shared hub constants: wide FIFO width, tag/payload header layout and the ID-width helper.
package hub_pkg;

    function automatic int id_width(input int n);
        return $clog2(n);
    endfunction

    localparam int HUB_FIFO_WIDTH          = 32;
    localparam int HUB_FIFO_PHYSICAL_WIDTH = HUB_FIFO_WIDTH;
    localparam int HUB_NUM_SOURCES         = 4;
    localparam int HUB_ID_WIDTH            = id_width(HUB_NUM_SOURCES);
    localparam int HUB_PAYLOAD_WIDTH       = HUB_FIFO_WIDTH - HUB_ID_WIDTH;
    localparam int ID_MSB                  = HUB_FIFO_WIDTH - 1;
    localparam int ID_LSB                  = HUB_PAYLOAD_WIDTH;

endpackage

// File: rtl/hub_out_buffer2.sv
// Two-entry valid/ready FIFO with registered outputs; head entry drives out_data directly.
module hub_out_buffer2
    import hub_pkg::*;
#(
    parameter int WIDTH = HUB_FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             valid_q;
    logic             pop;
    logic             push_ok;
    logic [1:0]       next_count;

    assign pop     = valid_q && out_ready;
    // A full buffer refuses pushes even when popping; the writer sees space only from registered count.
    assign push_ok = push && (count != 2'd2);

    always_comb begin
        next_count = count + 2'(push_ok) - 2'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= 2'd0;
            valid_q <= 1'b0;
            entry0  <= '0;
            entry1  <= '0;
        end else begin
            case ({push_ok, pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= push_data;
                    else               entry1 <= push_data;
                end
                2'b01: begin
                    entry0 <= entry1;
                end
                2'b11: begin
                    entry0 <= push_data;
                end
                default: ;
            endcase
            count   <= next_count;
            valid_q <= (next_count != 2'd0);
        end
    end

    assign out_data  = entry0;
    assign out_valid = valid_q;

endmodule

// File: rtl/hub_rr_packer.sv
// Round-robin merge of NUM_SOURCES payload streams into one {id, payload} stream
// feeding the hub serializer through a two-entry output buffer.
module hub_rr_packer
    import hub_pkg::id_width;
#(
    parameter int NUM_SOURCES    = 4,
    parameter int PAYLOAD_WIDTH  = 30,
    parameter int ID_WIDTH       = 2,
    parameter int HUB_FIFO_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_SOURCES*PAYLOAD_WIDTH-1:0] src_data,
    input  logic [NUM_SOURCES-1:0]             src_valid,
    output logic [NUM_SOURCES-1:0]             src_ready,
    output logic [HUB_FIFO_WIDTH-1:0]          wide_fifo_data,
    output logic                               wide_fifo_valid,
    input  logic                               wide_fifo_ready
);

    if (NUM_SOURCES < 2) begin : g_chk_sources
        $error("hub_rr_packer: NUM_SOURCES must be at least 2");
    end
    if (ID_WIDTH != id_width(NUM_SOURCES)) begin : g_chk_id
        $error("hub_rr_packer: ID_WIDTH must equal clog2(NUM_SOURCES)");
    end
    if (HUB_FIFO_WIDTH != ID_WIDTH + PAYLOAD_WIDTH) begin : g_chk_width
        $error("hub_rr_packer: HUB_FIFO_WIDTH must equal ID_WIDTH + PAYLOAD_WIDTH");
    end

    logic [ID_WIDTH-1:0]       last_grant;
    logic [ID_WIDTH-1:0]       pick;
    logic [ID_WIDTH-1:0]       cand;
    logic                      found;
    logic                      space;
    logic                      push;
    logic [1:0]                count;
    logic [PAYLOAD_WIDTH-1:0]  payload;
    logic [HUB_FIFO_WIDTH-1:0] packed_word;
    int                        idx;

    // Search starts just after the last granted source so every requester is reached within one lap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            idx  = (int'(last_grant) + k) % NUM_SOURCES;
            cand = ID_WIDTH'(idx);
            if (!found && src_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign space = (count != 2'd2);
    assign push  = space && found && !reset;

    always_comb begin
        src_ready = '0;
        if (push) src_ready[pick] = 1'b1;
    end

    assign payload     = src_data[pick*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    assign packed_word = {pick, payload};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= ID_WIDTH'(NUM_SOURCES - 1);
        end else if (push) begin
            last_grant <= pick;
        end
    end

    hub_out_buffer2 #(
        .WIDTH(HUB_FIFO_WIDTH)
    ) u_out_buffer (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(packed_word),
        .out_data (wide_fifo_data),
        .out_valid(wide_fifo_valid),
        .out_ready(wide_fifo_ready),
        .count    (count)
    );

endmodule

// File: tb/tb_hub_rr_packer.sv
// Directed and scoreboarded checks of the round-robin packer and its output buffer.
module tb_hub_rr_packer;

    localparam int N  = 4;
    localparam int PW = 30;
    localparam int IW = 2;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*PW-1:0] src_data;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [W-1:0]    wide_fifo_data;
    logic            wide_fifo_valid;
    logic            wide_fifo_ready;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0]  exp_q[$];
    logic [PW-1:0] cur[N];
    int            wait_cnt[N];
    int            max_wait;
    logic [N-1:0]  acc;
    logic [W-1:0]  head;

    always #5 clk = ~clk;

    hub_rr_packer #(
        .NUM_SOURCES(N),
        .PAYLOAD_WIDTH(PW),
        .ID_WIDTH(IW),
        .HUB_FIFO_WIDTH(W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .src_data(src_data),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .wide_fifo_data(wide_fifo_data),
        .wide_fifo_valid(wide_fifo_valid),
        .wide_fifo_ready(wide_fifo_ready)
    );

    function automatic logic [W-1:0] word(input int id, input logic [PW-1:0] p);
        return {IW'(id), p};
    endfunction

    function automatic logic [PW-1:0] pay(input int id);
        return PW'(32'h0000_0100 + 32'(id));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_payloads();
        for (int i = 0; i < N; i++) src_data[i*PW +: PW] = pay(i);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state, with every source requesting
        reset           = 1'b1;
        src_data        = '0;
        load_payloads();
        src_valid       = '1;
        wide_fifo_ready = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(wide_fifo_valid), 64'(0));
        chk("rst_data",  64'(wide_fifo_data),  64'(0));
        chk("rst_ready", 64'(src_ready),       64'(0));
        tick();
        reset = 1'b0;

        // Test 1: all sources valid, downstream always ready
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t1_ready", 64'(src_ready), 64'(4'b0001 << (c % 4)));
            if (c == 0) begin
                chk("t1_first_invalid", 64'(wide_fifo_valid), 64'(0));
            end else begin
                chk("t1_valid", 64'(wide_fifo_valid), 64'(1));
                chk("t1_data",  64'(wide_fifo_data),  64'(word((c - 1) % 4, pay((c - 1) % 4))));
            end
            tick();
        end

        // Test 2: only source 2 active
        pulse_reset();
        src_valid           = 4'b0100;
        src_data[2*PW +: PW] = 30'h155;
        wide_fifo_ready     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t2_ready", 64'(src_ready), 64'(4'b0100));
            if (c == 0) begin
                chk("t2_first_invalid", 64'(wide_fifo_valid), 64'(0));
            end else begin
                chk("t2_valid", 64'(wide_fifo_valid), 64'(1));
                chk("t2_data",  64'(wide_fifo_data),  64'(32'h8000_0155));
            end
            tick();
        end

        // Test 3: backpressure for five cycles
        pulse_reset();
        load_payloads();
        src_valid       = 4'b1111;
        wide_fifo_ready = 1'b0;
        @(negedge clk);
        chk("t3_ready0", 64'(src_ready), 64'(4'b0001));
        tick();
        @(negedge clk);
        chk("t3_ready1", 64'(src_ready), 64'(4'b0010));
        chk("t3_data1",  64'(wide_fifo_data), 64'(word(0, pay(0))));
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t3_full_ready", 64'(src_ready),       64'(0));
            chk("t3_full_valid", 64'(wide_fifo_valid), 64'(1));
            chk("t3_full_data",  64'(wide_fifo_data),  64'(word(0, pay(0))));
            tick();
        end

        // Test 4: single-cycle ready pulse on a full buffer
        wide_fifo_ready = 1'b1;
        @(negedge clk);
        chk("t4_pop_ready", 64'(src_ready),      64'(0));
        chk("t4_pop_data",  64'(wide_fifo_data), 64'(word(0, pay(0))));
        tick();
        wide_fifo_ready = 1'b0;
        @(negedge clk);
        chk("t4_push_ready", 64'(src_ready),      64'(4'b0100));
        chk("t4_push_data",  64'(wide_fifo_data), 64'(word(1, pay(1))));
        tick();
        @(negedge clk);
        chk("t4_refull_ready", 64'(src_ready),      64'(0));
        chk("t4_refull_data",  64'(wide_fifo_data), 64'(word(1, pay(1))));
        tick();
        wide_fifo_ready = 1'b1;
        @(negedge clk);
        chk("t4_drain0_ready", 64'(src_ready),      64'(0));
        chk("t4_drain0_data",  64'(wide_fifo_data), 64'(word(1, pay(1))));
        tick();
        @(negedge clk);
        chk("t4_drain1_ready", 64'(src_ready),      64'(4'b1000));
        chk("t4_drain1_data",  64'(wide_fifo_data), 64'(word(2, pay(2))));
        tick();
        @(negedge clk);
        chk("t4_drain2_ready", 64'(src_ready),      64'(4'b0001));
        chk("t4_drain2_data",  64'(wide_fifo_data), 64'(word(3, pay(3))));
        tick();

        // Test 5: async reset with a full buffer and source 3 waiting
        pulse_reset();
        src_valid       = 4'b1011;
        wide_fifo_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("t5_full_ready", 64'(src_ready),       64'(0));
        chk("t5_full_valid", 64'(wide_fifo_valid), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_valid", 64'(wide_fifo_valid), 64'(0));
        chk("t5_async_data",  64'(wide_fifo_data),  64'(0));
        chk("t5_async_ready", 64'(src_ready),       64'(0));
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_restart_ready", 64'(src_ready),       64'(4'b0001));
        chk("t5_restart_valid", 64'(wide_fifo_valid), 64'(0));
        tick();

        // Test 6: random traffic against a scoreboard
        pulse_reset();
        src_valid = '0;
        max_wait  = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!src_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    cur[i]               = PW'($urandom);
                    src_data[i*PW +: PW] = cur[i];
                    src_valid[i]         = 1'b1;
                end
            end
            wide_fifo_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("rnd_onehot", 64'($onehot0(src_ready)), 64'(1));
            chk("rnd_grant_has_valid", 64'(src_ready & ~src_valid), 64'(0));
            if (wide_fifo_valid && wide_fifo_ready) begin
                chk("rnd_nonempty", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    head = exp_q.pop_front();
                    chk("rnd_data", 64'(wide_fifo_data), 64'(head));
                end
            end
            acc = src_ready & src_valid;
            for (int j = 0; j < N; j++) begin
                if (acc[j]) begin
                    exp_q.push_back(word(j, cur[j]));
                    wait_cnt[j] = 0;
                    for (int i = 0; i < N; i++) begin
                        if (i != j && src_valid[i]) begin
                            wait_cnt[i]++;
                            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                        end
                    end
                end
            end
            tick();
            src_valid = src_valid & ~acc;
        end

        src_valid       = '0;
        wide_fifo_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (wide_fifo_valid) begin
                chk("drain_nonempty", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    head = exp_q.pop_front();
                    chk("drain_data", 64'(wide_fifo_data), 64'(head));
                end
            end
            tick();
        end
        chk("drain_all_delivered", 64'(exp_q.size()), 64'(0));
        chk("drain_idle", 64'(wide_fifo_valid), 64'(0));
        chk("no_starvation", 64'(max_wait <= N), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
